// File: rtl/host_req_arbiter.sv
// rtl/host_req_arbiter.sv - round-robin multiplexer of NUM_CH read/write channels onto one host port pair
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ch_start                       per-channel enable; 0 blocks new grants
//   ch_rd_* / ch_wr_*              per-channel request inputs (flattened), one-hot grants out
//   req_rd_* / req_wr_*            registered host request ports, gated by *_available
//   resp_rd_* / resp_wr_*          host responses, mdata = {channel id, tag}
//   ch_resp_rd_* / ch_resp_wr_*    registered per-channel responses (one-hot valid)
//   ch_idle                        channel has nothing outstanding in either direction
//   err                            sticky: a response hit an invalid id or an idle counter
//   total_rd / total_wr            free-running counts of issued host requests
module host_req_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 512,
    parameter int MDATA_W   = 16,
    parameter int MAX_OUTST = 32,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int TAG_W    = MDATA_W - CH_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_start,
    input  logic [NUM_CH-1:0]          ch_rd_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_rd_addr,
    input  logic [NUM_CH*TAG_W-1:0]    ch_rd_tag,
    output logic [NUM_CH-1:0]          ch_rd_grant,
    input  logic [NUM_CH-1:0]          ch_wr_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_wr_addr,
    input  logic [NUM_CH*TAG_W-1:0]    ch_wr_tag,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wr_data,
    output logic [NUM_CH-1:0]          ch_wr_grant,
    input  logic                       req_rd_available,
    output logic                       req_rd_en,
    output logic [ADDR_W-1:0]          req_rd_addr,
    output logic [MDATA_W-1:0]         req_rd_mdata,
    input  logic                       resp_rd_valid,
    input  logic [DATA_W-1:0]          resp_rd_data,
    input  logic [MDATA_W-1:0]         resp_rd_mdata,
    input  logic                       req_wr_available,
    output logic                       req_wr_en,
    output logic [ADDR_W-1:0]          req_wr_addr,
    output logic [DATA_W-1:0]          req_wr_data,
    output logic [MDATA_W-1:0]         req_wr_mdata,
    input  logic                       resp_wr_valid,
    input  logic [MDATA_W-1:0]         resp_wr_mdata,
    output logic [NUM_CH-1:0]          ch_resp_rd_valid,
    output logic [DATA_W-1:0]          ch_resp_rd_data,
    output logic [TAG_W-1:0]           ch_resp_rd_tag,
    output logic [NUM_CH-1:0]          ch_resp_wr_valid,
    output logic [TAG_W-1:0]           ch_resp_wr_tag,
    output logic [NUM_CH-1:0]          ch_idle,
    output logic                       err,
    output logic [63:0]                total_rd,
    output logic [63:0]                total_wr
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0] outst_rd [NUM_CH];
    logic [CNT_W-1:0] outst_wr [NUM_CH];
    logic [CH_W-1:0]  rd_ptr, wr_ptr;

    logic [NUM_CH-1:0] rd_elig, wr_elig;
    logic [CH_W:0]     rd_pick, wr_pick;
    logic [CH_W-1:0]   rd_win, wr_win;
    logic              rd_go, wr_go;

    logic [CH_W-1:0]   rd_rsp_id, wr_rsp_id;
    logic [NUM_CH-1:0] rd_hit, wr_hit;
    logic              rd_bad, wr_bad;

    // Returns {found, index}: first eligible channel at ptr+1, ptr+2, ... ptr+NUM_CH.
    // Scanning from the far end lets the nearest candidate overwrite the others.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                              input logic [CH_W-1:0]   ptr);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (elig[idx]) res = {1'b1, CH_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        rd_elig   = '0;
        wr_elig   = '0;
        rd_hit    = '0;
        wr_hit    = '0;
        ch_idle   = '0;
        rd_rsp_id = resp_rd_mdata[MDATA_W-1 -: CH_W];
        wr_rsp_id = resp_wr_mdata[MDATA_W-1 -: CH_W];
        for (int i = 0; i < NUM_CH; i++) begin
            rd_elig[i] = ch_rd_req[i] & ch_start[i] & (outst_rd[i] < CNT_W'(MAX_OUTST));
            wr_elig[i] = ch_wr_req[i] & ch_start[i] & (outst_wr[i] < CNT_W'(MAX_OUTST));
            // A response only routes to a real channel that is actually waiting on it.
            rd_hit[i]  = resp_rd_valid & (rd_rsp_id == CH_W'(i)) & (outst_rd[i] != '0);
            wr_hit[i]  = resp_wr_valid & (wr_rsp_id == CH_W'(i)) & (outst_wr[i] != '0);
            ch_idle[i] = (outst_rd[i] == '0) & (outst_wr[i] == '0);
        end
        rd_bad = resp_rd_valid & ~(|rd_hit);
        wr_bad = resp_wr_valid & ~(|wr_hit);

        rd_pick = rr_pick(rd_elig, rd_ptr);
        wr_pick = rr_pick(wr_elig, wr_ptr);
        rd_win  = rd_pick[CH_W-1:0];
        wr_win  = wr_pick[CH_W-1:0];
        rd_go   = rd_pick[CH_W] & req_rd_available;
        wr_go   = wr_pick[CH_W] & req_wr_available;

        ch_rd_grant = rd_go ? (NUM_CH'(1) << rd_win) : '0;
        ch_wr_grant = wr_go ? (NUM_CH'(1) << wr_win) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            req_rd_en        <= 1'b0;
            req_rd_addr      <= '0;
            req_rd_mdata     <= '0;
            req_wr_en        <= 1'b0;
            req_wr_addr      <= '0;
            req_wr_data      <= '0;
            req_wr_mdata     <= '0;
            ch_resp_rd_valid <= '0;
            ch_resp_rd_data  <= '0;
            ch_resp_rd_tag   <= '0;
            ch_resp_wr_valid <= '0;
            ch_resp_wr_tag   <= '0;
            err              <= 1'b0;
            total_rd         <= '0;
            total_wr         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                outst_rd[i] <= '0;
                outst_wr[i] <= '0;
            end
        end else begin
            req_rd_en <= rd_go;
            if (rd_go) begin
                rd_ptr       <= rd_win;
                req_rd_addr  <= ch_rd_addr[rd_win*ADDR_W +: ADDR_W];
                req_rd_mdata <= {rd_win, ch_rd_tag[rd_win*TAG_W +: TAG_W]};
            end

            req_wr_en <= wr_go;
            if (wr_go) begin
                wr_ptr       <= wr_win;
                req_wr_addr  <= ch_wr_addr[wr_win*ADDR_W +: ADDR_W];
                req_wr_data  <= ch_wr_data[wr_win*DATA_W +: DATA_W];
                req_wr_mdata <= {wr_win, ch_wr_tag[wr_win*TAG_W +: TAG_W]};
            end

            ch_resp_rd_valid <= rd_hit;
            if (resp_rd_valid) begin
                ch_resp_rd_tag  <= resp_rd_mdata[TAG_W-1:0];
                ch_resp_rd_data <= resp_rd_data;
            end
            ch_resp_wr_valid <= wr_hit;
            if (resp_wr_valid) begin
                ch_resp_wr_tag <= resp_wr_mdata[TAG_W-1:0];
            end

            // Grant and routed response in the same cycle cancel out.
            for (int i = 0; i < NUM_CH; i++) begin
                case ({ch_rd_grant[i], rd_hit[i]})
                    2'b10:   outst_rd[i] <= outst_rd[i] + CNT_W'(1);
                    2'b01:   outst_rd[i] <= outst_rd[i] - CNT_W'(1);
                    default: outst_rd[i] <= outst_rd[i];
                endcase
                case ({ch_wr_grant[i], wr_hit[i]})
                    2'b10:   outst_wr[i] <= outst_wr[i] + CNT_W'(1);
                    2'b01:   outst_wr[i] <= outst_wr[i] - CNT_W'(1);
                    default: outst_wr[i] <= outst_wr[i];
                endcase
            end

            if (rd_bad | wr_bad) err <= 1'b1;

            total_rd <= total_rd + 64'(req_rd_en);
            total_wr <= total_wr + 64'(req_wr_en);
        end
    end

endmodule

// File: tb/tb_host_req_arbiter.sv
// tb/tb_host_req_arbiter.sv - directed self-checking bench for host_req_arbiter
module tb_host_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 512;
    localparam int MW = 16;
    localparam int MO = 32;
    localparam int TW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      ch_start;
    logic [N-1:0]      ch_rd_req;
    logic [N*AW-1:0]   ch_rd_addr;
    logic [N*TW-1:0]   ch_rd_tag;
    logic [N-1:0]      ch_rd_grant;
    logic [N-1:0]      ch_wr_req;
    logic [N*AW-1:0]   ch_wr_addr;
    logic [N*TW-1:0]   ch_wr_tag;
    logic [N*DW-1:0]   ch_wr_data;
    logic [N-1:0]      ch_wr_grant;
    logic              req_rd_available;
    logic              req_rd_en;
    logic [AW-1:0]     req_rd_addr;
    logic [MW-1:0]     req_rd_mdata;
    logic              resp_rd_valid;
    logic [DW-1:0]     resp_rd_data;
    logic [MW-1:0]     resp_rd_mdata;
    logic              req_wr_available;
    logic              req_wr_en;
    logic [AW-1:0]     req_wr_addr;
    logic [DW-1:0]     req_wr_data;
    logic [MW-1:0]     req_wr_mdata;
    logic              resp_wr_valid;
    logic [MW-1:0]     resp_wr_mdata;
    logic [N-1:0]      ch_resp_rd_valid;
    logic [DW-1:0]     ch_resp_rd_data;
    logic [TW-1:0]     ch_resp_rd_tag;
    logic [N-1:0]      ch_resp_wr_valid;
    logic [TW-1:0]     ch_resp_wr_tag;
    logic [N-1:0]      ch_idle;
    logic              err;
    logic [63:0]       total_rd;
    logic [63:0]       total_wr;

    int n_cmp = 0;
    int n_bad = 0;

    host_req_arbiter #(
        .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .rst(rst), .ch_start(ch_start),
        .ch_rd_req(ch_rd_req), .ch_rd_addr(ch_rd_addr), .ch_rd_tag(ch_rd_tag),
        .ch_rd_grant(ch_rd_grant),
        .ch_wr_req(ch_wr_req), .ch_wr_addr(ch_wr_addr), .ch_wr_tag(ch_wr_tag),
        .ch_wr_data(ch_wr_data), .ch_wr_grant(ch_wr_grant),
        .req_rd_available(req_rd_available), .req_rd_en(req_rd_en),
        .req_rd_addr(req_rd_addr), .req_rd_mdata(req_rd_mdata),
        .resp_rd_valid(resp_rd_valid), .resp_rd_data(resp_rd_data),
        .resp_rd_mdata(resp_rd_mdata),
        .req_wr_available(req_wr_available), .req_wr_en(req_wr_en),
        .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data), .req_wr_mdata(req_wr_mdata),
        .resp_wr_valid(resp_wr_valid), .resp_wr_mdata(resp_wr_mdata),
        .ch_resp_rd_valid(ch_resp_rd_valid), .ch_resp_rd_data(ch_resp_rd_data),
        .ch_resp_rd_tag(ch_resp_rd_tag),
        .ch_resp_wr_valid(ch_resp_wr_valid), .ch_resp_wr_tag(ch_resp_wr_tag),
        .ch_idle(ch_idle), .err(err), .total_rd(total_rd), .total_wr(total_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_start         = '0;
        ch_rd_req        = '0;
        ch_rd_addr       = '0;
        ch_rd_tag        = '0;
        ch_wr_req        = '0;
        ch_wr_addr       = '0;
        ch_wr_tag        = '0;
        ch_wr_data       = '0;
        req_rd_available = 1'b1;
        req_wr_available = 1'b1;
        resp_rd_valid    = 1'b0;
        resp_rd_data     = '0;
        resp_rd_mdata    = '0;
        resp_wr_valid    = 1'b0;
        resp_wr_mdata    = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt [N];
        int g;
        logic [63:0] pat;

        do_reset();
        #1;
        check("rst_rd_grant", ch_rd_grant, 0);
        check("rst_wr_grant", ch_wr_grant, 0);
        check("rst_req_rd_en", req_rd_en, 0);
        check("rst_req_wr_en", req_wr_en, 0);
        check("rst_idle", ch_idle, 4'hf);
        check("rst_err", err, 0);
        check("rst_total_rd", total_rd, 0);
        check("rst_total_wr", total_wr, 0);
        check("rst_resp_rd_valid", ch_resp_rd_valid, 0);
        check("rst_rd_addr", req_rd_addr, 0);
        check("rst_rd_mdata", req_rd_mdata, 0);

        // Single requester: ch 2 reads 0x1000 with tag 5.
        ch_start = 4'hf;
        ch_rd_req = 4'b0100;
        ch_rd_addr[2*AW +: AW] = 48'h1000;
        ch_rd_tag[2*TW +: TW]  = 14'd5;
        #1;
        check("single_grant", ch_rd_grant, 4'b0100);
        tick();
        ch_rd_req = '0;
        #1;
        check("single_req_en", req_rd_en, 1);
        check("single_addr", req_rd_addr, 64'h1000);
        check("single_mdata", req_rd_mdata, 16'h8005);
        check("single_idle_busy", ch_idle, 4'b1011);
        tick();
        check("single_req_en_off", req_rd_en, 0);
        check("single_total_rd", total_rd, 1);
        pat = 64'hdead_beef_0000_0005;
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'h8005;
        resp_rd_data  = {8{pat}};
        #1;
        check("single_resp_latency", ch_resp_rd_valid, 0);
        tick();
        resp_rd_valid = 1'b0;
        #1;
        check("single_resp_valid", ch_resp_rd_valid, 4'b0100);
        check("single_resp_tag", ch_resp_rd_tag, 5);
        check("single_resp_data", ch_resp_rd_data[63:0], pat);
        check("single_idle_back", ch_idle, 4'hf);
        tick();
        check("single_resp_valid_off", ch_resp_rd_valid, 0);
        check("single_err", err, 0);

        // Fairness: all channels request continuously from ptr = 0.
        do_reset();
        ch_start  = 4'hf;
        ch_rd_req = 4'hf;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            check($sformatf("rr_seq_%0d", k), ch_rd_grant, 64'(1) << ((k + 1) % N));
            for (int i = 0; i < N; i++) if (ch_rd_grant[i]) cnt[i]++;
            tick();
        end
        ch_rd_req = '0;
        for (int i = 0; i < N; i++) check($sformatf("rr_count_%0d", i), cnt[i], 25);
        check("rr_idle", ch_idle, 0);
        tick();
        tick();
        check("rr_total_rd", total_rd, 100);

        // Credit limit on ch 0: exactly MAX_OUTST grants, then one per response.
        do_reset();
        ch_start  = 4'hf;
        ch_rd_req = 4'b0001;
        g = 0;
        for (int c = 0; c < MO + 8; c++) begin
            #1;
            if (ch_rd_grant[0]) g++;
            tick();
        end
        check("credit_grants", g, MO);
        #1;
        check("credit_blocked", ch_rd_grant, 0);
        check("credit_idle0", ch_idle[0], 0);
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'h0003;
        g = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ch_rd_grant[0]) g++;
            tick();
            resp_rd_valid = 1'b0;
        end
        check("credit_regrant", g, 1);
        ch_rd_req = '0;

        // Simultaneous grant and response on ch 1 leaves the counter at 1.
        do_reset();
        ch_start  = 4'hf;
        ch_rd_req = 4'b0010;
        #1;
        check("sim_first_grant", ch_rd_grant, 4'b0010);
        tick();
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'h4009;
        #1;
        check("sim_grant", ch_rd_grant, 4'b0010);
        tick();
        ch_rd_req = '0;
        resp_rd_valid = 1'b0;
        #1;
        check("sim_resp_valid", ch_resp_rd_valid, 4'b0010);
        check("sim_idle", ch_idle, 4'b1101);
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'h400a;
        tick();
        resp_rd_valid = 1'b0;
        #1;
        check("sim_idle_after", ch_idle, 4'hf);
        check("sim_err", err, 0);

        // Stop/drain on ch 3.
        do_reset();
        ch_start  = 4'hf;
        ch_rd_req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("drain_grant_%0d", c), ch_rd_grant, 4'b1000);
            tick();
        end
        ch_start = 4'b0111;
        #1;
        check("drain_stop_grant", ch_rd_grant, 0);
        tick();
        #1;
        check("drain_stop_grant2", ch_rd_grant, 0);
        check("drain_idle_busy", ch_idle, 4'b0111);
        for (int r = 0; r < 3; r++) begin
            resp_rd_valid = 1'b1;
            resp_rd_mdata = 16'hc000 | 16'(r);
            tick();
            resp_rd_valid = 1'b0;
            #1;
            check($sformatf("drain_resp_%0d", r), ch_resp_rd_valid, 4'b1000);
            check($sformatf("drain_idle_%0d", r), ch_idle[3], (r == 2) ? 1 : 0);
        end
        ch_rd_req = '0;
        check("drain_err", err, 0);

        // Bad response: ch 3 counter is zero.
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'hc007;
        tick();
        resp_rd_valid = 1'b0;
        #1;
        check("bad_resp_valid", ch_resp_rd_valid, 0);
        check("bad_err", err, 1);
        tick();
        tick();
        check("bad_err_sticky", err, 1);

        // Write backpressure, then release.
        pat = 64'h0123_4567_89ab_cdef;
        ch_start  = 4'hf;
        ch_wr_req = 4'hf;
        ch_wr_addr[1*AW +: AW] = 48'h2040;
        ch_wr_tag[1*TW +: TW]  = 14'h11;
        ch_wr_data[1*DW +: DW] = {8{pat}};
        req_wr_available = 1'b0;
        #1;
        check("bp_wr_grant", ch_wr_grant, 0);
        tick();
        #1;
        check("bp_wr_grant2", ch_wr_grant, 0);
        check("bp_req_wr_en", req_wr_en, 0);
        req_wr_available = 1'b1;
        #1;
        check("bp_release_grant", ch_wr_grant, 4'b0010);
        tick();
        ch_wr_req = '0;
        #1;
        check("wr_req_en", req_wr_en, 1);
        check("wr_addr", req_wr_addr, 64'h2040);
        check("wr_mdata", req_wr_mdata, 16'h4011);
        check("wr_data", req_wr_data[63:0], pat);
        tick();
        check("wr_total", total_wr, 1);
        check("wr_req_en_off", req_wr_en, 0);
        resp_wr_valid = 1'b1;
        resp_wr_mdata = 16'h4011;
        tick();
        resp_wr_valid = 1'b0;
        #1;
        check("wr_resp_valid", ch_resp_wr_valid, 4'b0010);
        check("wr_resp_tag", ch_resp_wr_tag, 14'h11);
        check("wr_idle", ch_idle, 4'hf);

        // Reset mid-operation clears err; a late response then sets it again.
        ch_rd_req = 4'b0001;
        tick();
        ch_rd_req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_err", err, 0);
        check("midrst_idle", ch_idle, 4'hf);
        check("midrst_total_rd", total_rd, 0);
        resp_rd_valid = 1'b1;
        resp_rd_mdata = 16'h0000;
        tick();
        resp_rd_valid = 1'b0;
        #1;
        check("midrst_late_resp_valid", ch_resp_rd_valid, 0);
        check("midrst_late_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
